// File: rtl/popcount_pkg.sv
// Shared constants, FSM state encodings and the round-robin pick helper
// for the popcount scheduler.
package popcount_pkg;

  localparam int WORD_W = 16;
  localparam int MAX_N  = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t GRANT = 2'd1;
  localparam state_t ACCUM = 2'd2;
  localparam state_t DONE  = 2'd3;

  // First set bit of valid, scanning ptr, ptr+1, ... modulo n; 0 if none set.
  function automatic logic [2:0] rr_pick(input logic [MAX_N-1:0] valid,
                                         input logic [2:0]       ptr,
                                         input int unsigned      n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/popcount16.sv
// Combinational 16-bit population count; the single datapath shared by
// all requesters.
module popcount16
  import popcount_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [4:0]        count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WORD_W; i++) begin
      count_o = count_o + 5'(word_i[i]);
    end
  end

endmodule

// File: rtl/popcount_sched.sv
// Round-robin scheduler: locks onto one requester per burst, sums the ones
// of every word through the shared popcount16 and returns a tagged total.
module popcount_sched
  import popcount_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = 12,
  parameter int ID_W  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        req_valid_i,
  input  logic [WORD_W*N-1:0] req_data_i,
  input  logic [N-1:0]        req_last_i,
  output logic [N-1:0]        req_ready_o,
  output logic                res_valid_o,
  output logic [ACC_W-1:0]    res_count_o,
  output logic [ID_W-1:0]     res_id_o,
  output logic                res_sat_o,
  input  logic                res_ready_i
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;

  logic [WORD_W-1:0]  word_sel;
  logic [4:0]         word_cnt;
  logic [ACC_W:0]     sum;
  logic [2:0]         pick_id;

  assign word_sel = req_data_i[WORD_W*gnt_id_q +: WORD_W];

  popcount16 u_popcount16 (
    .word_i  (word_sel),
    .count_o (word_cnt)
  );

  // One spare bit on the sum: its MSB flags overflow past the all-ones limit.
  assign sum     = {1'b0, acc_q} + {{(ACC_W-4){1'b0}}, word_cnt};
  assign pick_id = rr_pick(MAX_N'(req_valid_i), 3'(rr_ptr_q), N);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_id_d = gnt_id_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          gnt_id_d = pick_id[ID_W-1:0];
          acc_d    = '0;
          sat_d    = 1'b0;
          state_d  = GRANT;
        end
      end
      GRANT: state_d = ACCUM;
      ACCUM: begin
        if (req_valid_i[gnt_id_q]) begin
          if (sum[ACC_W]) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          if (req_last_i[gnt_id_q]) state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) begin
          rr_ptr_d = (gnt_id_q == ID_W'(N-1)) ? '0 : gnt_id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_id_q <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
    end
  end

  // Ready is decoded from registered state, so it rises the cycle after GRANT.
  always_comb begin
    req_ready_o = '0;
    if (state_q == ACCUM) req_ready_o[gnt_id_q] = 1'b1;
  end

  assign res_valid_o = (state_q == DONE);
  assign res_count_o = acc_q;
  assign res_id_o    = gnt_id_q;
  assign res_sat_o   = sat_q;

endmodule

// File: tb/tb_popcount_sched.sv
// Directed and randomised checks of popcount_sched; a second instance with a
// 5-bit accumulator exercises saturation.
module tb_popcount_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqValid, reqLast, reqReady;
  logic [63:0] reqData;
  logic        resValid, resSat, resReady;
  logic [11:0] resCount;
  logic [1:0]  resId;

  logic [3:0]  sReqValid, sReqLast, sReqReady;
  logic [63:0] sReqData;
  logic        sResValid, sResSat, sResReady;
  logic [4:0]  sResCount;
  logic [1:0]  sResId;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  popcount_sched #(.N(4), .ACC_W(12), .ID_W(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_data_i(reqData), .req_last_i(reqLast),
    .req_ready_o(reqReady),
    .res_valid_o(resValid), .res_count_o(resCount), .res_id_o(resId),
    .res_sat_o(resSat), .res_ready_i(resReady)
  );

  popcount_sched #(.N(4), .ACC_W(5), .ID_W(2)) dutSat (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(sReqValid), .req_data_i(sReqData), .req_last_i(sReqLast),
    .req_ready_o(sReqReady),
    .res_valid_o(sResValid), .res_count_o(sResCount), .res_id_o(sResId),
    .res_sat_o(sResSat), .res_ready_i(sResReady)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a single requester's word; all other valids are cleared.
  task automatic applyStimulus(input int r, input logic [15:0] w, input logic l);
    reqValid = 4'b0001 << r;
    reqLast  = 4'b0000;
    reqLast[r] = l;
    reqData[16*r +: 16] = w;
  endtask

  function automatic int softPop(input logic [15:0] w);
    int c = 0;
    for (int i = 0; i < 16; i++) if (w[i]) c++;
    return c;
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expIds [5] = '{0, 1, 2, 3, 0};
    int r, nWords, exp, guard;
    logic [15:0] w;

    rst = 1'b1; reqValid = 4'b1111; reqLast = 4'b1111; reqData = '1; resReady = 1'b0;
    sReqValid = '0; sReqLast = '0; sReqData = '0; sResReady = 1'b0;

    // Reset held with every requester asking.
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_ready", reqReady, 0);
      checkOutput("rst_res_valid", resValid, 0);
      checkOutput("rst_rr_ptr", dut.rr_ptr_q, 0);
    end
    checkOutput("rst_count", resCount, 0);
    checkOutput("rst_id", resId, 0);
    checkOutput("rst_sat", resSat, 0);
    rst = 1'b0; reqValid = '0; reqLast = '0; reqData = '0;
    tick();

    // Single word: A5A5 from req0, result at cycle 3.
    applyStimulus(0, 16'hA5A5, 1'b1);
    tick();
    checkOutput("sw_grant_ready", reqReady, 4'b0000);
    checkOutput("sw_grant_valid", resValid, 0);
    tick();
    checkOutput("sw_accum_ready", reqReady, 4'b0001);
    tick();
    reqValid = '0;
    checkOutput("sw_res_valid", resValid, 1);
    checkOutput("sw_count", resCount, 8);
    checkOutput("sw_id", resId, 0);
    checkOutput("sw_sat", resSat, 0);
    checkOutput("sw_done_ready", reqReady, 0);
    resReady = 1'b1;
    tick();
    resReady = 1'b0;
    checkOutput("sw_valid_drop", resValid, 0);

    // Burst from req2 with a two-cycle gap; req0 asks during the gap.
    applyStimulus(2, 16'hFFFF, 1'b0);
    tick();
    tick();
    checkOutput("bu_ready0", reqReady, 4'b0100);
    tick();
    reqValid = 4'b0001;
    checkOutput("bu_gap_ready1", reqReady, 4'b0100);
    tick();
    checkOutput("bu_gap_ready2", reqReady, 4'b0100);
    tick();
    applyStimulus(2, 16'h0000, 1'b0);
    tick();
    applyStimulus(2, 16'h0001, 1'b1);
    tick();
    reqValid = '0;
    checkOutput("bu_res_valid", resValid, 1);
    checkOutput("bu_count", resCount, 17);
    checkOutput("bu_id", resId, 2);
    resReady = 1'b1;
    tick();
    resReady = 1'b0;

    // Round robin from pointer 0 with everyone continuously requesting.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reqValid = 4'b1111; reqLast = 4'b1111; reqData = {4{16'h000F}};
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      tick();
      checkOutput("rr_res_valid", resValid, 1);
      checkOutput("rr_id", resId, expIds[k]);
      checkOutput("rr_count", resCount, 4);
      resReady = 1'b1;
      tick();
      resReady = 1'b0;
    end

    // Backpressure: pointer now 1, req1 carries 00FF.
    reqData[31:16] = 16'h00FF;
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", resValid, 1);
      checkOutput("bp_count", resCount, 8);
      checkOutput("bp_id", resId, 1);
      checkOutput("bp_ready", reqReady, 0);
      tick();
    end
    rst = 1'b1;
    tick();
    checkOutput("bp_rst_valid", resValid, 0);
    checkOutput("bp_rst_count", resCount, 0);
    rst = 1'b0; reqValid = '0; reqLast = '0; reqData = '0;

    // Saturation on the 5-bit instance.
    sReqValid = 4'b0010; sReqData[31:16] = 16'hFFFF; sReqLast = 4'b0000;
    tick();
    tick();
    checkOutput("sat_ready", sReqReady, 4'b0010);
    tick();
    sReqLast = 4'b0010;
    tick();
    sReqValid = '0;
    checkOutput("sat_valid", sResValid, 1);
    checkOutput("sat_count", sResCount, 31);
    checkOutput("sat_flag", sResSat, 1);
    checkOutput("sat_id", sResId, 1);
    sResReady = 1'b1;
    tick();
    sResReady = 1'b0;

    // Random bursts against a software popcount.
    for (int b = 0; b < 2000; b++) begin
      r = $urandom_range(0, 3);
      nWords = $urandom_range(1, 4);
      exp = 0;
      for (int k = 0; k < nWords; k++) begin
        case ($urandom_range(0, 7))
          0: w = 16'h0000;
          1: w = 16'hFFFF;
          default: w = 16'($urandom);
        endcase
        exp += softPop(w);
        applyStimulus(r, w, k == nWords - 1);
        guard = 0;
        while (!reqReady[r] && guard < 20) begin
          tick();
          guard++;
        end
        checkOutput("rand_ready", reqReady[r], 1);
        tick();
        if ($urandom_range(0, 3) == 0) begin
          reqValid = '0;
          tick();
        end
      end
      reqValid = '0;
      guard = 0;
      while (!resValid && guard < 20) begin
        tick();
        guard++;
      end
      checkOutput("rand_valid", resValid, 1);
      checkOutput("rand_count", resCount, exp);
      checkOutput("rand_id", resId, r);
      resReady = 1'b1;
      tick();
      resReady = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
